// File: rtl/adv_mode_cmd_writer_if.sv
// FIFO write port between the mode-command writer and the ADV7513 reconfiguration FIFO.
interface adv_mode_cmd_writer_if;
  logic       wrreq;
  logic [7:0] wdata;
  logic       wrfull;

  modport master (output wrreq, output wdata, input wrfull);
  modport slave  (input wrreq, input wdata, output wrfull);
endinterface

// File: rtl/adv_mode_cmd_writer.sv
// Builds the ADV7513 video-mode code from output_mode and a frame-filtered 240p flag,
// waits for it to settle, then writes exactly one byte per settled change into the FIFO.
module adv_mode_cmd_writer #(
  parameter int STABLE_FRAMES  = 3,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0]                  output_mode,
  input  logic                        is_240p,
  input  logic                        frame_strobe,
  input  logic                        force_resend,
  adv_mode_cmd_writer_if.master       fifo,
  output logic [3:0]                  current_code,
  output logic                        busy
);

  localparam int FW = $clog2(STABLE_FRAMES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [FW-1:0] FRAMES_LAST = FW'(STABLE_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLDOFF, WRITE} state_t;

  state_t          state;
  logic            flag_240p;
  logic [FW-1:0]   frame_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [3:0]      latched;
  logic            pending;
  logic [3:0]      desired;

  assign desired = {flag_240p, 1'b0, output_mode};

  // 240p filter: the flag only flips after STABLE_FRAMES consecutive disagreeing frame samples.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag_240p <= 1'b0;
      frame_cnt <= '0;
    end else if (frame_strobe) begin
      if (is_240p != flag_240p) begin
        if (frame_cnt == FRAMES_LAST) begin
          flag_240p <= ~flag_240p;
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end else begin
        frame_cnt <= '0;
      end
    end
  end

  // NOTE: pending resets to 1 so the first settled code after reset is always written,
  // keeping the downstream decoder in step with this block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b1;
    end else if (force_resend) begin
      pending <= 1'b1;
    end else if (state == WRITE && !fifo.wrfull) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      latched      <= 4'h0;
      fifo.wrreq   <= 1'b0;
      fifo.wdata   <= 8'h00;
      current_code <= 4'h0;
      busy         <= 1'b0;
    end else begin
      fifo.wrreq <= 1'b0;
      case (state)
        IDLE: begin
          if (pending || desired != current_code) begin
            state    <= HOLDOFF;
            busy     <= 1'b1;
            hold_cnt <= HOLD_LOAD;
            latched  <= desired;
          end
        end
        HOLDOFF: begin
          // Any movement of the desired code restarts the settle window; the counter stays >= 1 here.
          if (desired != latched) begin
            hold_cnt <= HOLD_LOAD;
            latched  <= desired;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
            if (hold_cnt == HW'(1)) state <= WRITE;
          end
        end
        WRITE: begin
          if (!fifo.wrfull) begin
            fifo.wrreq   <= 1'b1;
            fifo.wdata   <= {4'h0, latched};
            current_code <= latched;
            state        <= IDLE;
            busy         <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adv_mode_cmd_writer.sv
// Randomized and directed bench for adv_mode_cmd_writer against an event/deadline reference model.
module tb_adv_mode_cmd_writer;
  localparam int H  = 4;
  localparam int SF = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] output_mode = 2'd0;
  logic       is_240p = 1'b0;
  logic       frame_strobe = 1'b0;
  logic       force_resend = 1'b0;
  logic [3:0] current_code;
  logic       busy;

  adv_mode_cmd_writer_if fifo ();

  adv_mode_cmd_writer #(.STABLE_FRAMES(SF), .HOLDOFF_CYCLES(H)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .output_mode  (output_mode),
    .is_240p      (is_240p),
    .frame_strobe (frame_strobe),
    .force_resend (force_resend),
    .fifo         (fifo),
    .current_code (current_code),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a write is due H+1 cycles after the last (re)latch, once the FIFO has room.
  bit         m_flag;
  int         m_run;
  bit         m_pend;
  bit         m_armed;
  logic [3:0] m_lat;
  logic [3:0] m_cur;
  int         m_deadline;
  bit         m_wrreq;
  logic [7:0] m_wdata;

  int         n_writes = 0;
  int         last_wr_cyc = -1;
  logic [7:0] last_wr_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_flag = 1'b0; m_run = 0; m_pend = 1'b1; m_armed = 1'b0;
    m_lat = 4'h0; m_cur = 4'h0; m_deadline = 0; m_wrreq = 1'b0; m_wdata = 8'h00;
  endtask

  task automatic model_cycle();
    logic [3:0] des;
    bit clr;
    bit req;
    des = {m_flag, 1'b0, output_mode};
    clr = 1'b0;
    req = 1'b0;
    if (!m_armed) begin
      if (m_pend || des != m_cur) begin
        m_armed = 1'b1; m_lat = des; m_deadline = cyc + H + 1;
      end
    end else if (cyc < m_deadline) begin
      if (des != m_lat) begin
        m_lat = des; m_deadline = cyc + H + 1;
      end
    end else if (!fifo.wrfull) begin
      req = 1'b1; m_wdata = {4'h0, m_lat}; m_cur = m_lat; m_armed = 1'b0; clr = 1'b1;
    end
    m_wrreq = req;
    if (force_resend) m_pend = 1'b1;
    else if (clr) m_pend = 1'b0;
    if (frame_strobe) begin
      if (is_240p != m_flag) begin
        m_run++;
        if (m_run == SF) begin
          m_flag = ~m_flag; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // One cycle: compare at the falling edge, advance the model, then move to just after the next rising edge.
  task automatic step();
    @(negedge clock);
    check("wrreq", 32'(fifo.wrreq), 32'(m_wrreq));
    if (m_wrreq) check("wdata", 32'(fifo.wdata), 32'(m_wdata));
    check("current_code", 32'(current_code), 32'(m_cur));
    check("busy", 32'(busy), 32'(m_armed));
    if (fifo.wrreq === 1'b1) begin
      n_writes++;
      last_wr_cyc  = cyc;
      last_wr_data = fifo.wdata;
    end
    model_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  int w0, c0, s, r;

  initial begin
    fifo.wrfull = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_wrreq", 32'(fifo.wrreq), 32'd0);
    check("rst_wdata", 32'(fifo.wdata), 32'd0);
    check("rst_current", 32'(current_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Power-on write: single write at cycle 6 after release.
    reset_n = 1'b1;
    cyc = 0;
    run(200);
    check("por_count", 32'(n_writes), 32'd1);
    check("por_cycle", 32'(last_wr_cyc), 32'd6);
    check("por_data", 32'(last_wr_data), 32'h00);

    // Mode change 0 -> 2.
    w0 = n_writes; c0 = cyc;
    output_mode = 2'd2;
    run(20);
    check("m2_count", 32'(n_writes - w0), 32'd1);
    check("m2_cycle", 32'(last_wr_cyc), 32'(c0 + 6));
    check("m2_data", 32'(last_wr_data), 32'h02);
    check("m2_current", 32'(current_code), 32'h2);

    // Two 240p frames then a normal one: the filter must not flip.
    w0 = n_writes;
    is_240p = 1'b1;
    repeat (2) begin
      frame_strobe = 1'b1; step(); frame_strobe = 1'b0; step();
    end
    is_240p = 1'b0;
    frame_strobe = 1'b1; step(); frame_strobe = 1'b0;
    run(20);
    check("p240_short_count", 32'(n_writes - w0), 32'd0);

    // Three consecutive 240p frames flip the flag -> code 0xA.
    w0 = n_writes;
    is_240p = 1'b1;
    s = 0;
    repeat (3) begin
      frame_strobe = 1'b1; s = cyc; step(); frame_strobe = 1'b0; step();
    end
    run(20);
    check("p240_count", 32'(n_writes - w0), 32'd1);
    check("p240_cycle", 32'(last_wr_cyc), 32'(s + 7));
    check("p240_data", 32'(last_wr_data), 32'h0A);

    // Back to progressive, then toggle the mode faster than the hold-off window.
    is_240p = 1'b0;
    repeat (3) begin
      frame_strobe = 1'b1; step(); frame_strobe = 1'b0; step();
    end
    run(20);
    w0 = n_writes;
    for (int i = 0; i < 5; i++) begin
      output_mode = (i % 2 == 1) ? 2'd1 : 2'd0;
      run(2);
    end
    c0 = cyc;
    output_mode = 2'd3;
    run(20);
    check("toggle_count", 32'(n_writes - w0), 32'd1);
    check("toggle_cycle", 32'(last_wr_cyc), 32'(c0 + 6));
    check("toggle_data", 32'(last_wr_data), 32'h03);

    // FIFO full across the WRITE phase.
    w0 = n_writes;
    output_mode = 2'd1;
    fifo.wrfull = 1'b1;
    run(25);
    check("full_busy", 32'(busy), 32'd1);
    check("full_count", 32'(n_writes - w0), 32'd0);
    r = cyc;
    fifo.wrfull = 1'b0;
    run(10);
    check("full_rel_count", 32'(n_writes - w0), 32'd1);
    check("full_rel_cycle", 32'(last_wr_cyc), 32'(r + 1));
    check("full_rel_data", 32'(last_wr_data), 32'h01);

    // Forced resend of an unchanged code.
    w0 = n_writes; c0 = cyc;
    force_resend = 1'b1; step(); force_resend = 1'b0;
    run(20);
    check("resend_count", 32'(n_writes - w0), 32'd1);
    check("resend_cycle", 32'(last_wr_cyc), 32'(c0 + 7));
    check("resend_data", 32'(last_wr_data), 32'h01);

    // Randomized traffic against the model.
    repeat (800) begin
      if ($urandom_range(15) == 0) output_mode = 2'($urandom_range(3));
      is_240p      = 1'($urandom_range(1));
      frame_strobe = ($urandom_range(3) == 0);
      fifo.wrfull  = ($urandom_range(2) == 0);
      force_resend = ($urandom_range(31) == 0);
      step();
    end
    frame_strobe = 1'b0; force_resend = 1'b0; fifo.wrfull = 1'b0; is_240p = 1'b0;
    run(30);

    // Reset asserted during HOLDOFF.
    output_mode = m_cur[1:0] + 2'd1;
    run(2);
    check("mid_busy_before", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_wrreq", 32'(fifo.wrreq), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_current", 32'(current_code), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    w0 = n_writes;
    run(20);
    check("mid_por_count", 32'(n_writes - w0), 32'd1);
    check("mid_por_cycle", 32'(last_wr_cyc), 32'd6);
    check("mid_por_data", 32'(last_wr_data), 32'({6'd0, output_mode}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adv_mode_cmd_writer.md
Name: adv_mode_cmd_writer

Overview:
- Upstream producer for the ADV7513 reconfiguration FIFO.
- Builds the 4-bit video-mode code from the requested output mode and a frame-filtered 240p flag.
- Rate-limits changes with a hold-off window, then writes exactly one byte per settled change into the FIFO.
- The downstream reconfiguration stage decodes that byte into the active ADV7513 configuration.

Parameters:
- STABLE_FRAMES, 3: consecutive frame_strobe samples of a differing is_240p needed to flip the filtered 240p flag; legal range ≥1.
- HOLDOFF_CYCLES, 1024: clock cycles the desired code must stay unchanged before it is written; legal range ≥1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- output_mode  in  2  requested output: 0=1080p, 1=960p, 2=480p, 3=VGA.
- is_240p  in  1  raw 240p detect from the input timing stage.
- frame_strobe  in  1  one-cycle pulse per source frame.
- force_resend  in  1  one-cycle pulse; rewrites the current desired code even if unchanged.
- wrfull  in  1  FIFO full flag.
- wrreq  out  1  FIFO write enable; one-cycle pulse.
- wdata  out  8  FIFO write data = {4'h0, code}.
- current_code  out  4  last code written.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values (asynchronous, on reset_n low): wrreq=0, wdata=8'h00, current_code=4'h0, busy=0, state=IDLE, filtered 240p=0, frame counter=0, hold-off counter=0, pending=1.
- pending=1 at reset forces a power-on write so the downstream stage is synchronised.
- 240p filter:
  - is_240p is sampled only on cycles where frame_strobe=1.
  - Sample ≠ filtered flag: increment the counter.
  - When the incremented value equals STABLE_FRAMES: toggle the filtered flag and clear the counter.
  - Sample = filtered flag: clear the counter.
- desired code = {filtered240p, 1'b0, output_mode}. Legal codes are only 0x0–0x3 and 0x8–0xB.
- force_resend sets pending in any state. When it coincides with a WRITE completion, pending stays set.
- IDLE:
  - If pending=1 or desired ≠ current_code: go to HOLDOFF, load counter=HOLDOFF_CYCLES, latch desired.
- HOLDOFF:
  - If desired ≠ latched: reload counter=HOLDOFF_CYCLES and re-latch desired.
  - Otherwise decrement. When the counter reaches 1 and is decremented, go to WRITE the next cycle.
- WRITE:
  - While wrfull=1: hold in WRITE, wrreq=0. Changes to desired are ignored until back in IDLE.
  - When wrfull=0: next cycle drive wrreq=1 and wdata={4'h0, latched} for exactly one cycle. In that same cycle update current_code=latched, clear pending, return to IDLE.
- Latency: change first visible in cycle k, no further changes, wrfull=0 → HOLDOFF in cycles k+1..k+HOLDOFF_CYCLES, WRITE in cycle k+HOLDOFF_CYCLES+1, wrreq high in cycle k+HOLDOFF_CYCLES+2.
- At most one FIFO word per write sequence. wrreq is never high while wrfull was high in the preceding cycle.
- Hold-off counter width is $clog2(HOLDOFF_CYCLES+1). The counter must never wrap.
- Reset asserted mid-operation (any state): outputs drop to reset values immediately. After release the power-on write repeats.

Test Plan (HOLDOFF_CYCLES=4, STABLE_FRAMES=3):
- Release reset with output_mode=0, is_240p=0, wrfull=0 → single wrreq at cycle 6 after release with wdata=0x00. No further writes over 200 cycles; busy low after.
- output_mode 0→2 and held → one wrreq, wdata=0x02, current_code=2, at change cycle+6.
- output_mode=2, is_240p=1 for 2 frame_strobes then 0 → no write. Then is_240p=1 for 3 strobes → one write of 0x0A.
- output_mode toggling every 2 cycles for 10 cycles, then held at 3 → exactly one write, wdata=0x03, at settle cycle+6.
- wrfull=1 for 20 cycles while in WRITE → wrreq stays 0 and busy=1. Release wrfull → exactly one wrreq, one cycle later, with latched code.
- force_resend pulse with no change → rewrite of same code (e.g. 0x03).
- reset_n pulsed low during HOLDOFF → wrreq=0 and busy=0 immediately; after release the power-on write is issued with the current desired code.
